// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer driving key-expansion and stage handshakes with a per-state timeout
module aes_round_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] round_num,
  output logic       key_req,
  input  logic       key_ack,
  output logic       sb_en,
  input  logic       sb_done,
  output logic       sr_en,
  input  logic       sr_done,
  output logic       mc_en,
  input  logic       mc_done,
  output logic       ark_en,
  input  logic       ark_done,
  output logic       ark_sel_init,
  output logic       mc_bypass
);
  typedef enum logic [2:0] {IDLE, KEY, SB, SR, MC, ARK, DONE, ERR} state_e;
  state_e     state_q, state_d, adv;
  logic [7:0] wait_q, wait_d;
  logic [3:0] round_q, round_d;
  logic       in_stage, first, last, fin;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= 8'd0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    in_stage = state_q inside {KEY, SB, SR, MC, ARK};
    first    = wait_q == 8'd0;
    last     = round_q == 4'd10;
    fin      = state_q == KEY ? key_ack :
               state_q == SB  ? sb_done && !first :
               state_q == SR  ? sr_done && !first :
               state_q == MC  ? mc_done && !first :
               state_q == ARK ? ark_done && !first : 1'b0;
    adv      = state_q == KEY ? (round_q == 4'd0 ? ARK : SB) :
               state_q == SB  ? SR :
               state_q == SR  ? (last ? ARK : MC) :
               state_q == MC  ? ARK :
               last ? DONE : KEY;
    state_d  = state_q;
    round_d  = round_q;
    if (abort) begin
      state_d = IDLE;
      round_d = 4'd0;
    end else if ((state_q == IDLE || state_q == ERR) && start) begin
      state_d = KEY;
      round_d = 4'd0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (in_stage && fin) begin
      state_d = adv;
      round_d = (state_q == ARK && !last) ? round_q + 4'd1 : round_q;
    end else if (in_stage && wait_q == 8'(TIMEOUT - 1)) begin
      state_d = ERR;
    end
    wait_d = (in_stage && state_d == state_q) ? wait_q + 8'd1 : 8'd0;
  end

  always_comb begin
    busy         = state_q inside {KEY, SB, SR, MC, ARK};
    done         = state_q == DONE;
    error        = state_q == ERR;
    round_num    = round_q;
    key_req      = state_q == KEY;
    sb_en        = state_q == SB && wait_q == 8'd0;
    sr_en        = state_q == SR && wait_q == 8'd0;
    mc_en        = state_q == MC && wait_q == 8'd0;
    ark_en       = state_q == ARK && wait_q == 8'd0;
    ark_sel_init = round_q == 4'd0 && (state_q == ARK || state_q == KEY);
    mc_bypass    = round_q == 4'd10 && busy;
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench with handshake responders and a latency scoreboard for aes_round_ctrl
module tb_aes_round_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic busy, done, error, key_req, sb_en, sr_en, mc_en, ark_en, ark_sel_init, mc_bypass;
  logic [3:0] round_num;
  logic key_ack = 1'b0, sb_done = 1'b0, sr_done = 1'b0, mc_done = 1'b0, ark_done = 1'b0;
  logic sb_p = 1'b0, sr_p = 1'b0, mc_p = 1'b0, ark_p = 1'b0;
  logic hold_sb = 1'b0;
  int kdelay = 0, kcnt = 0;
  int checks = 0, errors = 0;
  int n_sb = 0, n_sr = 0, n_mc = 0, n_ark = 0, n_done = 0, n_mc10 = 0, n_byp = 0, n_asi = 0;
  int exp_q[$];
  logic [13:0] outs;

  aes_round_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error), .round_num(round_num),
    .key_req(key_req), .key_ack(key_ack),
    .sb_en(sb_en), .sb_done(sb_done), .sr_en(sr_en), .sr_done(sr_done),
    .mc_en(mc_en), .mc_done(mc_done), .ark_en(ark_en), .ark_done(ark_done),
    .ark_sel_init(ark_sel_init), .mc_bypass(mc_bypass)
  );

  always #5 clk = ~clk;
  assign outs = {busy, done, error, key_req, sb_en, sr_en, mc_en, ark_en, ark_sel_init, mc_bypass, round_num};

  always @(negedge clk) begin
    key_ack  = key_req && (kcnt >= kdelay);
    kcnt     = key_req ? kcnt + 1 : 0;
    sb_done  = sb_p && !(hold_sb && round_num == 4'd3);
    sr_done  = sr_p;
    mc_done  = mc_p;
    ark_done = ark_p;
    sb_p     = sb_en;
    sr_p     = sr_en;
    mc_p     = mc_en;
    ark_p    = ark_en;
  end

  always @(negedge clk) begin
    n_sb   += int'(sb_en);
    n_sr   += int'(sr_en);
    n_mc   += int'(mc_en);
    n_ark  += int'(ark_en);
    n_done += int'(done);
    n_mc10 += int'(mc_en && round_num == 4'd10);
    n_byp  += int'(mc_bypass);
    n_asi  += int'(ark_sel_init);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_evt(input string tag, input int which, input int rnd);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < 300) begin
      @(negedge clk);
      n++;
      hit = (which == 0 ? sb_en : which == 1 ? mc_en : ark_en) && round_num == 4'(rnd);
    end
    chk(tag, int'(hit), 1);
  endtask

  task automatic run_seq(input string tag, input int exp, input int restart);
    int cyc, d0, lat;
    d0 = n_done;
    exp_q.push_back(exp);
    pulse_start();
    cyc = 1;
    chk({tag, "_key0"}, int'({key_req, round_num}), 16);
    while (!done && cyc < 400) begin
      start = (cyc == restart);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done"}, int'(done), 1);
    lat = exp_q.pop_front();
    if (done) chk({tag, "_lat"}, cyc, lat);
    repeat (2) @(negedge clk);
    chk({tag, "_ndone"}, n_done - d0, 1);
    chk({tag, "_err"}, int'(error), 0);
  endtask

  initial begin
    int s_sb, s_sr, s_mc, s_ark, s_mc10, s_byp, s_asi, d0, cyc;
    repeat (3) @(negedge clk);
    chk("rst_outs", int'(outs), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", int'(outs), 0);

    s_sb = n_sb; s_sr = n_sr; s_mc = n_mc; s_ark = n_ark; s_mc10 = n_mc10; s_byp = n_byp; s_asi = n_asi;
    run_seq("zw", 92, -1);
    chk("zw_ark_en", n_ark - s_ark, 11);
    chk("zw_sb_en", n_sb - s_sb, 10);
    chk("zw_sr_en", n_sr - s_sr, 10);
    chk("zw_mc_en", n_mc - s_mc, 9);
    chk("zw_mc_en_r10", n_mc10 - s_mc10, 0);
    chk("zw_bypass_cycles", n_byp - s_byp, 7);
    chk("zw_sel_init_cycles", n_asi - s_asi, 3);
    chk("zw_round_hold", int'(round_num), 10);
    chk("zw_idle_busy", int'(busy), 0);

    kdelay = 5;
    run_seq("kdly", 147, -1);
    kdelay = 0;

    hold_sb = 1'b1;
    d0 = n_done;
    pulse_start();
    wait_evt("to_sb_r3", 0, 3);
    cyc = 0;
    while (!error && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_cycles", cyc, 16);
    chk("to_err_busy", int'({error, busy}), 2);
    repeat (5) @(negedge clk);
    chk("to_err_hold", int'(error), 1);
    chk("to_no_done", n_done - d0, 0);
    hold_sb = 1'b0;
    run_seq("err_restart", 92, -1);

    d0 = n_done;
    pulse_start();
    wait_evt("ab_mc_r5", 1, 5);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("ab_outs", int'(outs), 0);
    repeat (100) @(negedge clk);
    chk("ab_no_done", n_done - d0, 0);
    chk("ab_idle", int'({busy, error}), 0);

    d0 = n_done;
    pulse_start();
    wait_evt("rs_ark_r7", 2, 7);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rs_outs", int'(outs), 0);
    repeat (3) @(negedge clk);
    chk("rs_no_done_err", (n_done - d0) + int'(error), 0);
    run_seq("post_rst", 92, -1);

    run_seq("busy_start", 92, 20);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
